// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the memory and the arbiter.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_done, if_stall,
        input  d_rd, d_wr, d_addr, d_wdata,
        output d_rdata, d_done, d_stall,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_done
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_done, if_stall,
        output d_rd, d_wr, d_addr, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single variable-latency memory port,
// with fetch anti-starvation, a BUSY watchdog and a sticky error flag.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus,
    output logic          err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    logic        is_idle;
    logic        busy;
    logic        d_req_bad;
    logic        d_req_legal;
    logic        fetch_wins;
    logic        grant_if;
    logic        grant_d;
    logic        timeout_hit;
    logic        finish;
    logic [15:0] rdata_out;

    assign is_idle     = (state_q == IDLE);
    assign busy        = ~is_idle;
    assign d_req_bad   = bus.d_rd & bus.d_wr;
    assign d_req_legal = bus.d_rd ^ bus.d_wr;

    // Fetch takes the slot when data has nothing legal to offer, or once data
    // has been served STARVE_LIMIT times in a row while fetch was waiting.
    assign fetch_wins  = bus.if_req & (~d_req_legal | (starve_cnt_q == STARVE_MAX));
    assign grant_if    = is_idle & fetch_wins;
    assign grant_d     = is_idle & d_req_legal & ~fetch_wins;

    assign timeout_hit = busy & ~bus.mem_done & (tmo_cnt_q == TMO_LAST);
    assign finish      = busy & (bus.mem_done | timeout_hit);
    assign rdata_out   = timeout_hit ? 16'h0000 : bus.mem_rdata;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = (state_q == BUSY_IF) | ((state_q == BUSY_D) & ~wr_q);
    assign bus.mem_wr    = (state_q == BUSY_D) & wr_q;

    assign bus.if_done   = (state_q == BUSY_IF) & finish;
    assign bus.d_done    = (state_q == BUSY_D) & finish;
    assign bus.if_rdata  = rdata_out;
    assign bus.d_rdata   = rdata_out;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.d_stall   = (bus.d_rd | bus.d_wr) & ~bus.d_done;

    assign err = err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (d_req_bad) begin
                    err_d = 1'b1;
                end
                if (grant_if) begin
                    state_d      = BUSY_IF;
                    addr_d       = bus.if_addr;
                    wr_d         = 1'b0;
                    tmo_cnt_d    = 8'd0;
                    starve_cnt_d = 4'd0;
                end else if (grant_d) begin
                    state_d   = BUSY_D;
                    addr_d    = bus.d_addr;
                    wdata_d   = bus.d_wdata;
                    wr_d      = bus.d_wr;
                    tmo_cnt_d = 8'd0;
                    if (bus.if_req && (starve_cnt_q < STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                if (!bus.mem_done) begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
                if (timeout_hit) begin
                    err_d = 1'b1;
                end
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Async reset drops the strobes at once; an abandoned access never reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            wr_q         <= 1'b0;
            starve_cnt_q <= 4'd0;
            tmo_cnt_q    <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after each falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    logic err;
    int   total;
    int   bad;

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [11:0] d_pat;
    logic [11:0] f_pat;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 16'h0000;
        bus.d_rd      = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = 16'h0000;
        bus.d_wdata   = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_done  = 1'b0;

        // Reset state
        nxt(); nxt(); #1;
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_if_done", bus.if_done, 1'b0);
        chk("rst_d_done", bus.d_done, 1'b0);
        chk("rst_err", err, 1'b0);
        $display("reset state checked");

        // mem_done while idle is ignored
        nxt(); rst_n = 1'b1; bus.mem_done = 1'b1; #1;
        chk("idle_memdone_if_done", bus.if_done, 1'b0);
        chk("idle_memdone_d_done", bus.d_done, 1'b0);
        nxt(); #1;
        chk("idle_memdone_mem_rd", bus.mem_rd, 1'b0);
        $display("idle mem_done ignored");

        // Fetch read, memory answers on the 2nd BUSY cycle
        nxt(); bus.mem_done = 1'b0; bus.if_req = 1'b1; bus.if_addr = 16'h0010; #1;
        chk("f_idle_stall", bus.if_stall, 1'b1);
        chk("f_idle_mem_rd", bus.mem_rd, 1'b0);
        nxt(); #1;
        chk("f_b1_mem_rd", bus.mem_rd, 1'b1);
        chk("f_b1_mem_addr", bus.mem_addr, 16'h0010);
        chk("f_b1_if_done", bus.if_done, 1'b0);
        chk("f_b1_mem_wr", bus.mem_wr, 1'b0);
        nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hC0DE; #1;
        chk("f_b2_mem_rd", bus.mem_rd, 1'b1);
        chk("f_b2_if_done", bus.if_done, 1'b1);
        chk("f_b2_if_rdata", bus.if_rdata, 16'hC0DE);
        chk("f_b2_if_stall", bus.if_stall, 1'b0);
        nxt(); bus.if_req = 1'b0; bus.mem_done = 1'b0; #1;
        chk("f_end_mem_rd", bus.mem_rd, 1'b0);
        chk("f_end_if_done", bus.if_done, 1'b0);
        $display("fetch read transaction checked");

        // Data write and fetch together: data first, fetch after one IDLE cycle
        nxt();
        bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234; #1;
        chk("dw_idle_mem_wr", bus.mem_wr, 1'b0);
        nxt(); bus.mem_done = 1'b1; #1;
        chk("dw_b1_mem_wr", bus.mem_wr, 1'b1);
        chk("dw_b1_mem_rd", bus.mem_rd, 1'b0);
        chk("dw_b1_mem_addr", bus.mem_addr, 16'h0100);
        chk("dw_b1_mem_wdata", bus.mem_wdata, 16'h1234);
        chk("dw_b1_d_done", bus.d_done, 1'b1);
        chk("dw_b1_d_stall", bus.d_stall, 1'b0);
        nxt(); bus.d_wr = 1'b0; bus.mem_done = 1'b0; #1;
        chk("dw_gap_mem_wr", bus.mem_wr, 1'b0);
        chk("dw_gap_mem_rd", bus.mem_rd, 1'b0);
        chk("dw_gap_if_stall", bus.if_stall, 1'b1);
        nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF; #1;
        chk("dw_f_mem_rd", bus.mem_rd, 1'b1);
        chk("dw_f_mem_addr", bus.mem_addr, 16'h0020);
        chk("dw_f_if_done", bus.if_done, 1'b1);
        chk("dw_f_if_rdata", bus.if_rdata, 16'hBEEF);
        nxt(); bus.if_req = 1'b0; bus.mem_done = 1'b0; #1;
        chk("dw_end_mem_rd", bus.mem_rd, 1'b0);
        $display("data-over-fetch priority checked");

        // Starvation: 4 data grants, 1 fetch grant, data resumes
        d_pat = 12'b1000_1010_1010;
        f_pat = 12'b0010_0000_0000;
        nxt();
        bus.d_rd = 1'b1; bus.d_addr = 16'h0200;
        bus.if_req = 1'b1; bus.if_addr = 16'h0030;
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) nxt();
            #1;
            chk($sformatf("st_d_done_%0d", k), bus.d_done, d_pat[k]);
            chk($sformatf("st_if_done_%0d", k), bus.if_done, f_pat[k]);
            if (f_pat[k]) chk($sformatf("st_addr_%0d", k), bus.mem_addr, 16'h0030);
            if (d_pat[k]) chk($sformatf("st_addr_%0d", k), bus.mem_addr, 16'h0200);
            $display("starve cycle %0d d_done=%0b if_done=%0b", k, bus.d_done, bus.if_done);
        end

        // d_rd and d_wr together: error, no data grant, fetch still serviced
        nxt();
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0400;
        bus.if_req = 1'b1; bus.if_addr = 16'h0040; bus.mem_done = 1'b0; #1;
        chk("bad_idle_err", err, 1'b0);
        chk("bad_idle_d_stall", bus.d_stall, 1'b1);
        chk("bad_idle_mem_wr", bus.mem_wr, 1'b0);
        nxt(); bus.mem_done = 1'b1; bus.mem_rdata = 16'hAAAA; #1;
        chk("bad_b1_err", err, 1'b1);
        chk("bad_b1_mem_rd", bus.mem_rd, 1'b1);
        chk("bad_b1_mem_wr", bus.mem_wr, 1'b0);
        chk("bad_b1_mem_addr", bus.mem_addr, 16'h0040);
        chk("bad_b1_if_done", bus.if_done, 1'b1);
        chk("bad_b1_d_done", bus.d_done, 1'b0);
        chk("bad_b1_d_stall", bus.d_stall, 1'b1);
        nxt(); bus.if_req = 1'b0; bus.mem_done = 1'b0; #1;
        chk("bad_i1_mem_rd", bus.mem_rd, 1'b0);
        chk("bad_i1_mem_wr", bus.mem_wr, 1'b0);
        nxt(); #1;
        chk("bad_i2_mem_rd", bus.mem_rd, 1'b0);
        chk("bad_i2_mem_wr", bus.mem_wr, 1'b0);
        chk("bad_i2_d_stall", bus.d_stall, 1'b1);
        chk("bad_i2_err", err, 1'b1);
        $display("illegal data request checked");

        // Reset in the middle of a data write, then clean re-grant
        nxt();
        bus.d_rd = 1'b0; bus.d_wr = 1'b1; bus.d_addr = 16'h0500; bus.d_wdata = 16'h9999; #1;
        nxt(); #1;
        chk("rb_b1_mem_wr", bus.mem_wr, 1'b1);
        #2 rst_n = 1'b0; #1;
        chk("rb_async_mem_wr", bus.mem_wr, 1'b0);
        chk("rb_async_d_done", bus.d_done, 1'b0);
        chk("rb_async_mem_addr", bus.mem_addr, 16'h0000);
        chk("rb_async_err", err, 1'b0);
        nxt(); bus.mem_done = 1'b1; #1;
        chk("rb_hold_mem_wr", bus.mem_wr, 1'b0);
        chk("rb_hold_d_done", bus.d_done, 1'b0);
        nxt(); rst_n = 1'b1; bus.mem_done = 1'b0; #1;
        chk("rb_rel_mem_wr", bus.mem_wr, 1'b0);
        nxt(); bus.mem_done = 1'b1; #1;
        chk("rb_re_mem_wr", bus.mem_wr, 1'b1);
        chk("rb_re_mem_addr", bus.mem_addr, 16'h0500);
        chk("rb_re_mem_wdata", bus.mem_wdata, 16'h9999);
        chk("rb_re_d_done", bus.d_done, 1'b1);
        nxt(); bus.d_wr = 1'b0; bus.mem_done = 1'b0; #1;
        chk("rb_end_mem_wr", bus.mem_wr, 1'b0);
        $display("reset mid-access checked");

        // Watchdog: memory never answers, abort on BUSY cycle 8
        nxt();
        bus.d_rd = 1'b1; bus.d_addr = 16'h0300; bus.mem_rdata = 16'h5555; #1;
        for (int b = 1; b <= 8; b++) begin
            nxt(); #1;
            chk($sformatf("to_mem_rd_%0d", b), bus.mem_rd, 1'b1);
            chk($sformatf("to_d_done_%0d", b), bus.d_done, (b == 8) ? 1'b1 : 1'b0);
            chk($sformatf("to_err_%0d", b), err, 1'b0);
            if (b == 1) chk("to_mem_addr", bus.mem_addr, 16'h0300);
            if (b == 8) chk("to_d_rdata", bus.d_rdata, 16'h0000);
            $display("timeout busy cycle %0d d_done=%0b", b, bus.d_done);
        end
        nxt(); bus.d_rd = 1'b0; #1;
        chk("to_after_err", err, 1'b1);
        chk("to_after_mem_rd", bus.mem_rd, 1'b0);
        chk("to_after_d_done", bus.d_done, 1'b0);
        nxt(); nxt(); #1;
        chk("to_sticky_err", err, 1'b1);
        $display("timeout abort checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: max consecutive data grants while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT, default 64, range 2..255: max BUSY cycles before abort.
REQ-003 SHALL have one clock, clk; reset rst_n is asynchronous, active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 if_req  in  1  fetch read request, held until if_done.
REQ-007 if_addr  in  16  fetch address.
REQ-008 if_rdata  out  16  fetch read data, valid with if_done.
REQ-009 if_done  out  1  fetch completion pulse.
REQ-010 if_stall  out  1  if_req & ~if_done.
REQ-011 d_rd / d_wr  in  1 each  data read / write request, held until d_done.
REQ-012 d_addr, d_wdata  in  16 each  data address, write data.
REQ-013 d_rdata  out  16  data read data, valid with d_done.
REQ-014 d_done  out  1  data completion pulse.
REQ-015 d_stall  out  1  (d_rd | d_wr) & ~d_done.
REQ-016 mem_addr, mem_wdata  out  16 each  memory address, write data.
REQ-017 mem_rd, mem_wr  out  1 each  memory read / write strobe.
REQ-018 mem_rdata  in  16  memory read data.
REQ-019 mem_done  in  1  memory completion, any latency >= 1 cycle.
REQ-020 err  out  1  sticky error flag.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, BUSY_IF, BUSY_D.
REQ-022 IDLE: a data request wins over if_req, except when starve_cnt == STARVE_LIMIT and if_req is high, in which case fetch wins.
REQ-023 IDLE, no legal request: stay IDLE with all strobes low.
REQ-024 On grant, SHALL register the winner's address, write data and read/write kind; the next cycle enters BUSY_IF or BUSY_D.
REQ-025 BUSY_*: mem_addr and mem_wdata come from the registered values; mem_rd (fetch or data read) or mem_wr (data write) SHALL stay high every BUSY cycle until completion.
REQ-026 Completion SHALL occur in the first BUSY cycle with mem_done = 1; next state is IDLE.
REQ-027 if_done = BUSY_IF & mem_done, combinational; if_rdata = mem_rdata pass-through.
REQ-028 d_done = BUSY_D & mem_done; d_rdata = mem_rdata pass-through; d_rdata is don't-care for writes.
REQ-029 Minimum latency SHALL be request seen in IDLE at cycle 0, strobe at cycle 1, done at cycle 1 if mem_done is high; the next grant is no earlier than cycle 3 (one IDLE cycle between accesses).
REQ-030 starve_cnt (4-bit) SHALL increment on a data grant when if_req is high, clear on a fetch grant, hold otherwise, and saturate at STARVE_LIMIT.
REQ-031 tmo_cnt (8-bit) SHALL clear on entering BUSY and increment each BUSY cycle without mem_done.
REQ-032 When tmo_cnt == TIMEOUT-1 without mem_done: pulse the active requester's done, force its rdata to 16'h0000, set err, return to IDLE, and drop the strobe.
REQ-033 d_rd & d_wr both high in IDLE: SHALL set err and not grant data; fetch MAY still be granted.
REQ-034 Request inputs SHALL be ignored while BUSY; a request withdrawn mid-BUSY SHALL NOT abort the memory access.
REQ-035 mem_done while IDLE SHALL be ignored.
REQ-036 err SHALL clear only on reset.
REQ-037 mem_rd and mem_wr SHALL never be high together.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, regardless of clk.
REQ-039 Reset values: mem_rd = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, if_done = 0, d_done = 0, err = 0, starve_cnt = 0, tmo_cnt = 0.
REQ-040 Reset mid-BUSY SHALL abandon the access with no done pulse; the first grant is possible on the first clk edge after rst_n rises.

Verification
REQ-041 Scenario: if_req=1, if_addr=16'h0010, mem_done at the 2nd BUSY cycle with mem_rdata=16'hC0DE -> mem_rd high 2 cycles, if_done pulses once with if_rdata=16'hC0DE, mem_addr=16'h0010.
REQ-042 Scenario: if_req and d_wr together, d_addr=16'h0100, d_wdata=16'h1234 -> data granted first (mem_wr, mem_wdata=16'h1234); fetch granted after the IDLE cycle.
REQ-043 Scenario: STARVE_LIMIT=4, d_rd always high, if_req high -> 4 data grants, then 1 fetch grant, then data resumes; the pattern repeats.
REQ-044 Scenario: TIMEOUT=8, mem_done never asserted -> done pulses on BUSY cycle 8 with rdata 16'h0000, err=1 and stays 1.
REQ-045 Scenario: d_rd=d_wr=1 -> err=1, no mem_wr/mem_rd, d_stall=1; a concurrent if_req is still serviced.
REQ-046 Scenario: rst_n pulled low mid-BUSY_D -> mem_wr drops asynchronously, no d_done; after release, a pending request is re-granted cleanly.
